pong_ctrl: RTL and testbench
============================

Name: pong_ctrl

Overview:
Game-flow controller that consumes the hit/miss events from the pong graphics block and drives its `graph_still` input.
- Sequences idle → serve wait → play → point scored → game over.
- Keeps per-player BCD scores and attributes each miss to the player who last hit the ball.
- Sits between the graphics block and the score/text display logic; frame pacing comes from the 60 Hz screen-refresh tick.

Parameters:
- WAIT_FRAMES, 120, frame ticks spent in NEWBALL and OVER (≥1; 120 = 2 s at 60 Hz).
- WIN_SCORE, 8'h09, BCD score that ends the game.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- frame_tick  input  1  one-cycle pulse at start of vertical refresh
- btn_start  input  1  start button, level
- hit_left  input  1  ball touching left paddle (level, may persist several cycles)
- hit_right  input  1  ball touching right paddle (level)
- miss  input  1  ball past a paddle (level, persists until ball recentred)
- graph_still  output  1  freeze/recentre request to graphics block
- game_over  output  1  high in OVER
- winner  output  1  0 = left player won, 1 = right; valid while game_over
- state  output  2  00 IDLE, 01 NEWBALL, 10 PLAY, 11 OVER
- score_left  output  8  two BCD digits
- score_right  output  8  two BCD digits
- rally  output  8  see Optional Feature

Behaviour:
- Reset (asynchronous on reset_n=0):
  - state=IDLE, graph_still=1, game_over=0, winner=0, scores=8'h00, timer=0, last_hit=LEFT, rally=0.
  - btn_prev=1, so a button held through reset does not start a game.
- Start detect: start_rise = btn_start & ~btn_prev; btn_prev is registered every cycle.
- All outputs are registered and derived from state:
  - graph_still = (state != PLAY).
  - game_over = (state == OVER).
- IDLE:
  - start_rise → clear both scores, load timer=WAIT_FRAMES, last_hit=LEFT, go to NEWBALL.
  - frame_tick, hit and miss are ignored.
- NEWBALL:
  - Each frame_tick decrements timer.
  - The frame_tick that takes timer from 1 to 0 also moves state to PLAY on the same edge.
  - NEWBALL therefore lasts exactly WAIT_FRAMES ticks; graph_still falls on the cycle after that tick.
- PLAY:
  - hit_left=1 → last_hit=LEFT; hit_right=1 → last_hit=RIGHT; if both are high, LEFT wins.
  - miss=1 → the last_hit player scores: left if last_hit=LEFT, else right.
  - Score increment is BCD: low digit 9 wraps to 0 with carry; 8'h99 saturates.
  - Miss beats hit in the same cycle; that hit does not update last_hit.
  - After a miss, if the new score == WIN_SCORE: go to OVER, winner = scoring side, timer=WAIT_FRAMES.
  - Otherwise: go to NEWBALL, timer=WAIT_FRAMES, last_hit=LEFT (the serve travels toward the right paddle).
- Single count per miss:
  - The first miss cycle leaves PLAY; graph_still rises the next cycle.
  - miss still asserted in NEWBALL/OVER is ignored, so exactly one point per miss event.
- OVER:
  - Each frame_tick decrements timer; the tick reaching 0 goes to IDLE.
  - start_rise is ignored in OVER.
  - Scores and winner stay held through IDLE until the next start clears the scores.
- frame_tick in IDLE or PLAY does not touch timer.
- Reset mid-game returns immediately to IDLE with scores cleared.

Optional Feature:
Macro PONG_CTRL_RALLY_EN.
- Defined:
  - rally counts rising edges of (hit_left|hit_right) in PLAY, using a hit_prev register so a multi-cycle hit counts once.
  - Binary count, saturating at 255.
  - Cleared on entry to PLAY; held otherwise.
- Undefined: rally is tied to 8'h00 and no hit_prev/rally registers exist.

Test Plan:
All scenarios use WAIT_FRAMES=2, WIN_SCORE=8'h02 unless noted.
1. reset_n low with btn_start=1, then release while btn_start stays 1 → state=00, graph_still=1, scores 00. No start until btn_start goes 0 then 1, after which state=01.
2. From NEWBALL, two frame_ticks 10 cycles apart → state=10 on the edge of the second tick; graph_still=0 one cycle later. One tick alone leaves state=01.
3. In PLAY with no hits, miss held 6 cycles → score_left=8'h01 exactly once, state=01, graph_still=1, score_right=00.
4. In PLAY: hit_right 3 cycles, then miss → score_right=8'h01. After the next serve, a miss with no hit → score_left increments (last_hit reset to LEFT).
5. With score_left=01, a left-attributed miss → score_left=02, state=11, game_over=1, winner=0. After 2 frame_ticks state=00 with scores held; start_rise → scores 00, state=01.
6. WIN_SCORE=8'h99, 10 left-attributed misses → score_left=8'h10. With PONG_CTRL_RALLY_EN defined, three 4-cycle hit pulses in one rally → rally=3, and rally=0 after the next serve enters PLAY.

Source files
------------

// File: rtl/pong_ctrl.sv
// pong_ctrl: game-flow FSM (IDLE/NEWBALL/PLAY/OVER) with per-player BCD scores; optional rally counter under PONG_CTRL_RALLY_EN.
// Latency: state/scores update on the edge an event is sampled; graph_still/game_over follow state one cycle later. No backpressure: events are level inputs, sampled every cycle.
module pong_ctrl #(
  parameter int         WAIT_FRAMES = 120,
  parameter logic [7:0] WIN_SCORE   = 8'h09
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       hit_left,
  input  logic       hit_right,
  input  logic       miss,
  output logic       graph_still,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] state,
  output logic [7:0] score_left,
  output logic [7:0] score_right,
  output logic [7:0] rally
);

  localparam int TW = (WAIT_FRAMES < 2) ? 1 : $clog2(WAIT_FRAMES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(WAIT_FRAMES);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_NEWBALL = 2'b01,
    ST_PLAY    = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [7:0]     score_l_q, score_l_d;
  logic [7:0]     score_r_q, score_r_d;
  logic           last_hit_q, last_hit_d;
  logic           winner_q, winner_d;
  logic           btn_prev_q;
  logic           graph_still_q;
  logic           game_over_q;
  logic           start_rise;
  logic [7:0]     new_score;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] >= 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign start_rise = btn_start & ~btn_prev_q;
  assign new_score  = bcd_inc((last_hit_q == SIDE_RIGHT) ? score_r_q : score_l_q);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    last_hit_d = last_hit_q;
    winner_d   = winner_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          score_l_d  = 8'h00;
          score_r_d  = 8'h00;
          timer_d    = TIMER_LOAD;
          last_hit_d = SIDE_LEFT;
          state_d    = ST_NEWBALL;
        end
      end
      ST_NEWBALL: begin
        if (frame_tick) begin
          if (timer_q <= TIMER_ONE) begin
            timer_d = '0;
            state_d = ST_PLAY;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
      end
      ST_PLAY: begin
        // A miss takes priority; a hit in the same cycle must not re-attribute it.
        if (miss) begin
          if (last_hit_q == SIDE_RIGHT)
            score_r_d = new_score;
          else
            score_l_d = new_score;
          timer_d = TIMER_LOAD;
          if (new_score == WIN_SCORE) begin
            winner_d = last_hit_q;
            state_d  = ST_OVER;
          end else begin
            last_hit_d = SIDE_LEFT;
            state_d    = ST_NEWBALL;
          end
        end else if (hit_left) begin
          last_hit_d = SIDE_LEFT;
        end else if (hit_right) begin
          last_hit_d = SIDE_RIGHT;
        end
      end
      ST_OVER: begin
        if (frame_tick) begin
          if (timer_q <= TIMER_ONE) begin
            timer_d = '0;
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      score_l_q     <= 8'h00;
      score_r_q     <= 8'h00;
      last_hit_q    <= SIDE_LEFT;
      winner_q      <= 1'b0;
      btn_prev_q    <= 1'b1;
      graph_still_q <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      last_hit_q    <= last_hit_d;
      winner_q      <= winner_d;
      btn_prev_q    <= btn_start;
      graph_still_q <= (state_q != ST_PLAY);
      game_over_q   <= (state_q == ST_OVER);
    end
  end

  assign graph_still = graph_still_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign state       = state_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;

`ifdef PONG_CTRL_RALLY_EN
  logic       hit_prev_q;
  logic [7:0] rally_q;
  logic       hit_any;

  assign hit_any = hit_left | hit_right;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_prev_q <= 1'b0;
      rally_q    <= 8'h00;
    end else begin
      hit_prev_q <= hit_any;
      if (state_q != ST_PLAY && state_d == ST_PLAY)
        rally_q <= 8'h00;
      else if (state_q == ST_PLAY && hit_any && !hit_prev_q && rally_q != 8'hFF)
        rally_q <= rally_q + 8'd1;
    end
  end

  assign rally = rally_q;
`else
  assign rally = 8'h00;
`endif

endmodule

// File: tb/tb_pong_ctrl.sv
// Bench for pong_ctrl: directed game-flow steps on a WIN=02 instance, then randomized rallies on a WIN=99 instance vs. an integer score model.
module tb_pong_ctrl;
  logic clk = 1'b0;
  logic reset_n, frame_tick, btn_start, hit_left, hit_right, miss;

  logic       a_still, a_over, a_winner;
  logic [1:0] a_state;
  logic [7:0] a_sl, a_sr, a_rally;
  logic       b_still, b_over, b_winner;
  logic [1:0] b_state;
  logic [7:0] b_sl, b_sr, b_rally;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pong_ctrl #(.WAIT_FRAMES(2), .WIN_SCORE(8'h02)) dut_a (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .btn_start(btn_start),
    .hit_left(hit_left), .hit_right(hit_right), .miss(miss),
    .graph_still(a_still), .game_over(a_over), .winner(a_winner), .state(a_state),
    .score_left(a_sl), .score_right(a_sr), .rally(a_rally));

  pong_ctrl #(.WAIT_FRAMES(2), .WIN_SCORE(8'h99)) dut_b (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .btn_start(btn_start),
    .hit_left(hit_left), .hit_right(hit_right), .miss(miss),
    .graph_still(b_still), .game_over(b_over), .winner(b_winner), .state(b_state),
    .score_left(b_sl), .score_right(b_sr), .rally(b_rally));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic press();
    btn_start = 1'b0;
    @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [7:0] bcd(input int n);
    int m;
    m = (n > 99) ? 99 : n;
    return 8'((m / 10) * 16 + (m % 10));
  endfunction

  // Serve on instance B: two ticks with random spacing, then the ball is live.
  task automatic serve_b();
    for (int i = 0; i < 2; i++) begin
      cyc($urandom_range(0, 3));
      tick();
    end
    chk("serve_state", 32'(b_state), 32'd2);
    chk("serve_rally_clear", 32'(b_rally), 32'd0);
    cyc(1);
    chk("serve_still", 32'(b_still), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sl, sr, last, cnt, nh, side, exp_rally;
    bit force_left;

    reset_n = 1'b0; btn_start = 1'b1; frame_tick = 1'b0;
    hit_left = 1'b0; hit_right = 1'b0; miss = 1'b0;
    cyc(3);
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_still", 32'(a_still), 32'd1);
    chk("rst_over", 32'(a_over), 32'd0);
    chk("rst_winner", 32'(a_winner), 32'd0);
    chk("rst_sl", 32'(a_sl), 32'h00);
    chk("rst_sr", 32'(a_sr), 32'h00);
    chk("rst_rally", 32'(a_rally), 32'h00);

    // Button held through reset must not start a game.
    reset_n = 1'b1;
    cyc(5);
    chk("held_btn_no_start", 32'(a_state), 32'd0);
    press();
    chk("start_newball", 32'(a_state), 32'd1);
    chk("newball_still", 32'(a_still), 32'd1);

    tick();
    cyc(9);
    chk("one_tick_stays", 32'(a_state), 32'd1);
    tick();
    chk("second_tick_play", 32'(a_state), 32'd2);
    chk("still_lags", 32'(a_still), 32'd1);
    cyc(1);
    chk("still_falls", 32'(a_still), 32'd0);

    // Long miss without hits: exactly one point to the left player.
    miss = 1'b1;
    cyc(1);
    chk("miss_sl", 32'(a_sl), 32'h01);
    chk("miss_state", 32'(a_state), 32'd1);
    cyc(1);
    chk("miss_still", 32'(a_still), 32'd1);
    cyc(4);
    miss = 1'b0;
    cyc(1);
    chk("miss_once_sl", 32'(a_sl), 32'h01);
    chk("miss_once_sr", 32'(a_sr), 32'h00);

    // Right hits then miss: point to the right player.
    tick(); cyc(2); tick();
    chk("serve2_play", 32'(a_state), 32'd2);
    cyc(1);
    hit_right = 1'b1;
    cyc(3);
    hit_right = 1'b0;
    cyc(1);
    miss = 1'b1;
    cyc(1);
    chk("right_scores", 32'(a_sr), 32'h01);
    chk("right_scores_sl", 32'(a_sl), 32'h01);
    cyc(2);
    miss = 1'b0;

    // After serve last_hit is LEFT; a simultaneous hit_right loses to the miss.
    tick(); cyc(1); tick();
    cyc(1);
    miss = 1'b1; hit_right = 1'b1;
    cyc(1);
    hit_right = 1'b0;
    chk("win_sl", 32'(a_sl), 32'h02);
    chk("win_sr", 32'(a_sr), 32'h01);
    chk("win_state", 32'(a_state), 32'd3);
    chk("win_winner", 32'(a_winner), 32'd0);
    cyc(1);
    chk("win_game_over", 32'(a_over), 32'd1);
    cyc(2);
    miss = 1'b0;
    chk("over_miss_ignored", 32'(a_sl), 32'h02);
    press();
    chk("over_start_ignored", 32'(a_state), 32'd3);
    tick();
    cyc(1);
    chk("over_one_tick", 32'(a_state), 32'd3);
    tick();
    chk("over_to_idle", 32'(a_state), 32'd0);
    chk("idle_sl_held", 32'(a_sl), 32'h02);
    chk("idle_sr_held", 32'(a_sr), 32'h01);
    chk("idle_winner_held", 32'(a_winner), 32'd0);
    cyc(1);
    chk("idle_game_over", 32'(a_over), 32'd0);
    press();
    chk("restart_state", 32'(a_state), 32'd1);
    chk("restart_sl", 32'(a_sl), 32'h00);
    chk("restart_sr", 32'(a_sr), 32'h00);

    // Instance B has accumulated points; reset mid-game clears it.
    chk("b_pre_reset_sl", 32'(b_sl), 32'h02);
    reset_n = 1'b0;
    cyc(2);
    chk("midgame_rst_state", 32'(b_state), 32'd0);
    chk("midgame_rst_sl", 32'(b_sl), 32'h00);
    chk("midgame_rst_sr", 32'(b_sr), 32'h00);
    reset_n = 1'b1;
    cyc(2);
    press();
    chk("b_start", 32'(b_state), 32'd1);

    // Randomized rallies on B; first ten are forced to the left player.
    sl = 0; sr = 0;
    for (int r = 0; r < 80; r++) begin
      force_left = (r < 10);
      serve_b();
      nh = $urandom_range(0, 4);
      last = 0; cnt = 0;
      for (int h = 0; h < nh; h++) begin
        side = $urandom_range(0, 2);
        if (force_left && h == nh - 1 && side == 1) side = 0;
        hit_left  = (side != 1);
        hit_right = (side != 0);
        cyc($urandom_range(1, 4));
        hit_left = 1'b0; hit_right = 1'b0;
        cyc($urandom_range(1, 2));
        last = (side == 1) ? 1 : 0;
        cnt++;
      end
`ifdef PONG_CTRL_RALLY_EN
      exp_rally = (cnt > 255) ? 255 : cnt;
`else
      exp_rally = 0;
`endif
      chk("rally_count", 32'(b_rally), 32'(exp_rally));
      miss = 1'b1;
      cyc(1);
      if (last == 1) sr++; else sl++;
      chk("rnd_sl", 32'(b_sl), 32'(bcd(sl)));
      chk("rnd_sr", 32'(b_sr), 32'(bcd(sr)));
      chk("rnd_state", 32'(b_state), 32'd1);
      cyc($urandom_range(0, 5));
      miss = 1'b0;
      cyc(1);
      chk("rnd_hold_sl", 32'(b_sl), 32'(bcd(sl)));
      chk("rnd_hold_sr", 32'(b_sr), 32'(bcd(sr)));
      if (r == 9) chk("bcd_carry_10", 32'(b_sl), 32'h10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
